// File: rtl/camera_pixel_packer_pkg.sv
// Shared types and constants for the camera pixel packer and the frame uploader that drains its queue.
package camera_pixel_packer_types;

    localparam int QUEUE_WORD_WIDTH = 17;
    localparam logic [QUEUE_WORD_WIDTH-1:0] FRAME_MARKER = 17'h10000;

    typedef enum logic [7:0] {
        IDLE      = 8'h01,
        WAIT_RISE = 8'h02,
        WAIT_FALL = 8'h04,
        MARKER    = 8'h08,
        CAPTURE   = 8'h10
    } state_t;

    function automatic logic [QUEUE_WORD_WIDTH-1:0] pixel_word(input logic [15:0] pixel);
        return {1'b0, pixel};
    endfunction

endpackage

// File: rtl/camera_pixel_packer_edge.sv
// Registers the synchronised camera VSYNC/HREF and produces single-cycle rise/fall pulses.
module cam_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    input  logic href,
    output logic vs_rise,
    output logic vs_fall,
    output logic href_rise,
    output logic href_fall
);

    logic vsync_q;
    logic href_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
        end
    end

    assign vs_rise   = vsync & ~vsync_q;
    assign vs_fall   = ~vsync & vsync_q;
    assign href_rise = href & ~href_q;
    assign href_fall = ~href & href_q;

endmodule

// File: rtl/camera_pixel_packer.sv
// Packs OV7670 byte pairs into RGB565 queue words, with a frame-start marker and drop accounting.
// Define PIXEL_COUNT_CHECK_EN to add the per-line / per-frame geometry check.
//
// state     | meaning
// IDLE      | not capturing; waits for enable
// WAIT_RISE | joined outside blanking; waits for VSYNC to rise
// WAIT_FALL | in vertical blanking; waits for VSYNC to fall
// MARKER    | frame marker pending until the queue has room
// CAPTURE   | packing and writing pixels until the next VSYNC rise
module camera_pixel_packer
    import camera_pixel_packer_types::*;
#(
    parameter int FRAME_WIDTH   = 640,
    parameter int FRAME_HEIGHT  = 480,
    parameter int OVF_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        cam_vsync,
    input  logic                        cam_href,
    input  logic                        cam_byte_valid,
    input  logic [7:0]                  cam_data,
    input  logic                        queue_full,
    output logic                        queue_wr_en,
    output logic [QUEUE_WORD_WIDTH-1:0] queue_data,
    output logic                        frame_start,
    output logic                        frame_done,
    output logic                        overflow,
    output logic [OVF_CNT_WIDTH-1:0]    drop_count,
    output logic                        byte_error,
    output logic                        geometry_error
);

    state_t state;
    logic   phase;
    logic [7:0] pix_hi;

    logic vs_rise, vs_fall, href_rise, href_fall;
    logic in_frame, byte_take, phase_eff, phase_next, pix_done, odd_end;
    logic drop_pix, drop_marker;
    logic [OVF_CNT_WIDTH:0] drop_sum;

    cam_edge_detect u_edge (
        .clk       (clk),
        .reset     (reset),
        .vsync     (cam_vsync),
        .href      (cam_href),
        .vs_rise   (vs_rise),
        .vs_fall   (vs_fall),
        .href_rise (href_rise),
        .href_fall (href_fall)
    );

    // A byte arriving on the same cycle HREF drops is still part of the line.
    assign in_frame    = (state == MARKER) || (state == CAPTURE);
    assign byte_take   = in_frame && cam_byte_valid && (cam_href || href_fall);
    assign phase_eff   = href_rise ? 1'b0 : phase;
    assign phase_next  = byte_take ? ~phase_eff : phase_eff;
    assign pix_done    = byte_take && phase_eff;
    assign odd_end     = href_fall && phase_next;
    assign drop_pix    = pix_done && ((state == MARKER) || queue_full);
    assign drop_marker = (state == MARKER) && vs_rise;

    assign drop_sum = {1'b0, drop_count}
                    + (OVF_CNT_WIDTH+1)'(drop_pix)
                    + (OVF_CNT_WIDTH+1)'(drop_marker);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= 1'b0;
            pix_hi      <= 8'h00;
            queue_wr_en <= 1'b0;
            queue_data  <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            byte_error  <= 1'b0;
        end else begin
            queue_wr_en <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;

            if (in_frame) begin
                phase <= odd_end ? 1'b0 : phase_next;
                if (byte_take && !phase_eff) begin
                    pix_hi <= cam_data;
                end
                if (odd_end) begin
                    byte_error <= 1'b1;
                end
            end else begin
                phase <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= cam_vsync ? WAIT_FALL : WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (vs_rise) begin
                        state <= WAIT_FALL;
                    end
                end
                WAIT_FALL: begin
                    if (vs_fall) begin
                        state <= MARKER;
                    end
                end
                MARKER: begin
                    if (vs_rise) begin
                        state <= WAIT_FALL;
                    end else if (!queue_full) begin
                        queue_wr_en <= 1'b1;
                        queue_data  <= FRAME_MARKER;
                        frame_start <= 1'b1;
                        state       <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (pix_done && !queue_full) begin
                        queue_wr_en <= 1'b1;
                        queue_data  <= pixel_word({pix_hi, cam_data});
                    end
                    if (vs_rise) begin
                        frame_done <= 1'b1;
                        state      <= enable ? WAIT_FALL : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop_pix || drop_marker) begin
            overflow   <= 1'b1;
            drop_count <= drop_sum[OVF_CNT_WIDTH] ? '1 : drop_sum[OVF_CNT_WIDTH-1:0];
        end
    end

`ifdef PIXEL_COUNT_CHECK_EN
    localparam int PIX_CNT_W  = $clog2(FRAME_WIDTH + 1) + 1;
    localparam int LINE_CNT_W = $clog2(FRAME_HEIGHT + 1);

    logic [PIX_CNT_W-1:0]  pix_cnt, pix_cnt_next;
    logic [LINE_CNT_W-1:0] line_cnt;

    // Counts written and dropped pixels alike; saturation keeps an oversize line flagged.
    assign pix_cnt_next = (pix_done && (pix_cnt != '1)) ? pix_cnt + PIX_CNT_W'(1) : pix_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt        <= '0;
            line_cnt       <= '0;
            geometry_error <= 1'b0;
        end else if ((state == WAIT_FALL) && vs_fall) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else if (in_frame) begin
            if (href_rise) begin
                pix_cnt <= '0;
            end else if (href_fall) begin
                if (pix_cnt_next != PIX_CNT_W'(FRAME_WIDTH)) begin
                    geometry_error <= 1'b1;
                end
                pix_cnt <= '0;
                if (line_cnt != '1) begin
                    line_cnt <= line_cnt + LINE_CNT_W'(1);
                end
            end else begin
                pix_cnt <= pix_cnt_next;
            end
            if ((state == CAPTURE) && vs_rise && (line_cnt != LINE_CNT_W'(FRAME_HEIGHT))) begin
                geometry_error <= 1'b1;
            end
        end
    end
`else
    assign geometry_error = 1'b0;
`endif

endmodule

// File: tb/tb_camera_pixel_packer.sv
// Directed bench for camera_pixel_packer: table of pixel vectors plus hand-written frame sequences.
module tb_camera_pixel_packer;
    import camera_pixel_packer_types::*;

`ifdef PIXEL_COUNT_CHECK_EN
    localparam logic GEOM_EN = 1'b1;
`else
    localparam logic GEOM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cam_vsync;
    logic        cam_href;
    logic        cam_byte_valid;
    logic [7:0]  cam_data;
    logic        queue_full;
    logic        queue_wr_en;
    logic [16:0] queue_data;
    logic        frame_start;
    logic        frame_done;
    logic        overflow;
    logic [15:0] drop_count;
    logic        byte_error;
    logic        geometry_error;

    camera_pixel_packer #(
        .FRAME_WIDTH   (4),
        .FRAME_HEIGHT  (2),
        .OVF_CNT_WIDTH (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .cam_vsync      (cam_vsync),
        .cam_href       (cam_href),
        .cam_byte_valid (cam_byte_valid),
        .cam_data       (cam_data),
        .queue_full     (queue_full),
        .queue_wr_en    (queue_wr_en),
        .queue_data     (queue_data),
        .frame_start    (frame_start),
        .frame_done     (frame_done),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .byte_error     (byte_error),
        .geometry_error (geometry_error)
    );

    always #5 clk = ~clk;

    int n_vec   = 0;
    int n_fail  = 0;
    int wr_count = 0;

    always @(posedge clk) begin
        #2;
        if (queue_wr_en === 1'b1) wr_count++;
    end

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic        full;
        logic        exp_wr;
        logic [16:0] exp_data;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic frame_begin();
        bit seen;
        seen = 1'b0;
        cam_vsync = 1'b1;
        repeat (3) cyc();
        cam_vsync = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cyc();
            if (queue_wr_en === 1'b1) seen = 1'b1;
        end
        check("marker_seen", 32'(seen), 32'd1);
        check("marker_data", 32'(queue_data), 32'(FRAME_MARKER));
        check("frame_start", 32'(frame_start), 32'd1);
    endtask

    task automatic frame_end();
        cam_vsync = 1'b1;
        cyc();
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        cyc();
        check("frame_done_clear", 32'(frame_done), 32'd0);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        cam_data       = v.hi;
        cam_byte_valid = 1'b1;
        cyc();
        cam_data   = v.lo;
        queue_full = v.full;
        cyc();
        cam_byte_valid = 1'b0;
        queue_full     = 1'b0;
        check($sformatf("vec%0d_wr_en", idx), 32'(queue_wr_en), 32'(v.exp_wr));
        check($sformatf("vec%0d_data", idx), 32'(queue_data), 32'(v.exp_data));
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_data       = b;
        cam_byte_valid = 1'b1;
        cyc();
        cam_byte_valid = 1'b0;
    endtask

    initial begin
        int base;

        tbl[0]  = '{8'hF8, 8'h00, 1'b0, 1'b1, 17'h0F800};
        tbl[1]  = '{8'h07, 8'hE0, 1'b0, 1'b1, 17'h007E0};
        tbl[2]  = '{8'h00, 8'h1F, 1'b0, 1'b1, 17'h0001F};
        tbl[3]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 17'h0FFFF};
        tbl[4]  = '{8'h12, 8'h34, 1'b0, 1'b1, 17'h01234};
        tbl[5]  = '{8'hAB, 8'hCD, 1'b0, 1'b1, 17'h0ABCD};
        tbl[6]  = '{8'h80, 8'h01, 1'b0, 1'b1, 17'h08001};
        tbl[7]  = '{8'h55, 8'hAA, 1'b0, 1'b1, 17'h055AA};
        tbl[8]  = '{8'h11, 8'h22, 1'b1, 1'b0, 17'h10000};
        tbl[9]  = '{8'h33, 8'h44, 1'b1, 1'b0, 17'h10000};
        tbl[10] = '{8'h55, 8'h66, 1'b1, 1'b0, 17'h10000};
        tbl[11] = '{8'h77, 8'h88, 1'b0, 1'b1, 17'h07788};
        tbl[12] = '{8'h99, 8'hAA, 1'b0, 1'b1, 17'h099AA};
        tbl[13] = '{8'hBB, 8'hCC, 1'b0, 1'b1, 17'h0BBCC};
        tbl[14] = '{8'hDD, 8'hEE, 1'b0, 1'b1, 17'h0DDEE};
        tbl[15] = '{8'h01, 8'h02, 1'b0, 1'b1, 17'h00102};

        reset          = 1'b1;
        enable         = 1'b0;
        cam_vsync      = 1'b0;
        cam_href       = 1'b0;
        cam_byte_valid = 1'b0;
        cam_data       = 8'h00;
        queue_full     = 1'b0;
        repeat (2) cyc();
        check("reset_flags", {26'd0, queue_wr_en, frame_start, frame_done, overflow, byte_error, geometry_error}, 32'd0);
        check("reset_data", 32'(queue_data), 32'd0);
        check("reset_drops", 32'(drop_count), 32'd0);
        reset = 1'b0;
        cyc();
        enable = 1'b1;
        cyc();

        // Two normal frames, the second with three pixels hitting a full queue.
        for (int i = 0; i < 16; i++) begin
            if (i % 8 == 0) frame_begin();
            if (i % 4 == 0) begin
                cam_href = 1'b1;
                cyc();
            end
            apply_vec(tbl[i], i);
            if (i % 4 == 3) begin
                cam_href = 1'b0;
                cyc();
                cyc();
            end
            if (i % 8 == 7) frame_end();
        end
        check("ovf_drop_count", 32'(drop_count), 32'd3);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_byte_error", 32'(byte_error), 32'd0);
        check("ovf_geometry", 32'(geometry_error), 32'd0);

        // Odd line: seven bytes on one HREF pulse.
        frame_begin();
        cam_href = 1'b1;
        cyc();
        base = wr_count;
        for (int k = 0; k < 7; k++) send_byte(8'(8'h10 + k));
        cam_href = 1'b0;
        cyc();
        cyc();
        check("odd_writes", 32'(wr_count - base), 32'd3);
        check("odd_last_data", 32'(queue_data), 32'h01415);
        check("odd_byte_error", 32'(byte_error), 32'd1);
        check("odd_geometry", 32'(geometry_error), 32'(GEOM_EN));
        frame_end();

        // Reset after a phase-0 byte, then a marker stall across two pixels.
        frame_begin();
        cam_href = 1'b1;
        cyc();
        send_byte(8'hAA);
        reset = 1'b1;
        #1;
        check("rst_async_flags", {26'd0, queue_wr_en, frame_start, frame_done, overflow, byte_error, geometry_error}, 32'd0);
        check("rst_async_data", 32'(queue_data), 32'd0);
        check("rst_async_drops", 32'(drop_count), 32'd0);
        cyc();
        cyc();
        reset = 1'b0;
        base = wr_count;
        send_byte(8'hBB);
        cam_href = 1'b0;
        cyc();
        cam_vsync = 1'b1;
        repeat (3) cyc();
        cam_vsync  = 1'b0;
        queue_full = 1'b1;
        cyc();
        cam_href = 1'b1;
        cyc();
        send_byte(8'h21);
        send_byte(8'h22);
        send_byte(8'h23);
        send_byte(8'h24);
        repeat (4) cyc();
        check("stall_no_write", 32'(wr_count - base), 32'd0);
        queue_full = 1'b0;
        cyc();
        check("stall_marker_wr", 32'(queue_wr_en), 32'd1);
        check("stall_marker_data", 32'(queue_data), 32'(FRAME_MARKER));
        check("stall_drop_count", 32'(drop_count), 32'd2);
        check("stall_overflow", 32'(overflow), 32'd1);
        send_byte(8'hCA);
        send_byte(8'hFE);
        check("stall_pix_wr", 32'(queue_wr_en), 32'd1);
        check("stall_pix_data", 32'(queue_data), 32'h0CAFE);
        cam_href = 1'b0;
        cyc();
        enable = 1'b0;
        frame_end();

        // Join mid-frame: enable rises during active lines.
        cam_vsync = 1'b0;
        cyc();
        cam_href = 1'b1;
        cyc();
        enable = 1'b1;
        base = wr_count;
        for (int k = 0; k < 8; k++) send_byte(8'(8'h40 + k));
        cam_href = 1'b0;
        cyc();
        cyc();
        check("join_no_write", 32'(wr_count - base), 32'd0);
        frame_begin();
        check("join_first_is_marker", 32'(wr_count - base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
